ddr3_user_port_arbiter: RTL and testbench

// - Shares the single user port of ddr3_memory_controller between two requesters (port 0, port 1).
// - Round-robin grant, one command in flight to the controller at a time.
// - Tags each accepted read with its port ID and routes the returned read data back to that port in order.
// - Sits between the user logic (e.g. loopback tester) and the ddr3_memory_controller user interface.

---
 rtl/ddr3_user_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ddr3_user_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_user_port_arbiter.sv
// ddr3_user_port_arbiter: shares the single ddr3_memory_controller user port
// between two requesters. Round-robin grant with one command in flight at a
// time. Read tags (port IDs) are queued so that returned read data is routed
// back to the requesting port in order.
// Optional build macro: ARB_WRITE_PRIORITY_EN (an eligible write beats any read).
module ddr3_user_port_arbiter #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int MAX_OUTSTANDING       = 4
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              p0_req_valid,
  input  logic                                              p0_req_write,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] p0_req_address,
  input  logic [DQ_BITWIDTH-1:0]                            p0_req_wdata,
  output logic                                              p0_req_ready,
  output logic                                              p0_rsp_valid,
  output logic [DQ_BITWIDTH-1:0]                            p0_rsp_rdata,
  input  logic                                              p1_req_valid,
  input  logic                                              p1_req_write,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] p1_req_address,
  input  logic [DQ_BITWIDTH-1:0]                            p1_req_wdata,
  output logic                                              p1_req_ready,
  output logic                                              p1_rsp_valid,
  output logic [DQ_BITWIDTH-1:0]                            p1_rsp_rdata,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            i_user_data,
  input  logic                                              ctrl_ready,
  input  logic                                              ctrl_rdata_valid,
  input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
  output logic                                              err_unexpected
);

  localparam int AW    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int DW    = DQ_BITWIDTH;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              winner_q, winner_d;
  logic              we_q, we_d, re_q, re_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
  logic              p0_rsp_valid_q, p0_rsp_valid_d, p1_rsp_valid_q, p1_rsp_valid_d;
  logic [DW-1:0]     p0_rsp_rdata_q, p0_rsp_rdata_d, p1_rsp_rdata_q, p1_rsp_rdata_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Tag FIFO storage: one bit per outstanding read, holding the port ID.
  logic              tag_mem [MAX_OUTSTANDING];

  logic fifo_full, fifo_empty, pop_en, push_en, can_push;
  logic elig0, elig1, any_elig, pick, pick_write, head_tag;

  // Eligibility and winner selection; a same-cycle pop frees a slot for a read.
  always_comb begin
    fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    fifo_empty = (count_q == '0);
    pop_en     = ctrl_rdata_valid && !fifo_empty;
    can_push   = !fifo_full || pop_en;
    elig0      = p0_req_valid && (p0_req_write || can_push);
    elig1      = p1_req_valid && (p1_req_write || can_push);
    any_elig   = elig0 || elig1;
    // Tie goes to the port that was not granted last.
    pick       = (elig0 && elig1) ? ~last_grant_q : elig1;
`ifdef ARB_WRITE_PRIORITY_EN
    // Writes outrank reads; round-robin only settles same-class ties.
    if (elig0 && elig1 && (p0_req_write != p1_req_write)) begin
      pick = p1_req_write;
    end
`endif
    pick_write = pick ? p1_req_write : p0_req_write;
  end

  // Next-state, command latch, tag FIFO pointer and response computation.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    winner_d       = winner_q;
    we_d           = we_q;
    re_d           = re_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    p0_ready_d     = 1'b0;
    p1_ready_d     = 1'b0;
    p0_rsp_valid_d = 1'b0;
    p1_rsp_valid_d = 1'b0;
    p0_rsp_rdata_d = p0_rsp_rdata_q;
    p1_rsp_rdata_d = p1_rsp_rdata_q;
    err_d          = err_q;
    push_en        = 1'b0;
    head_tag       = tag_mem[rd_ptr_q];

    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          winner_d   = pick;
          we_d       = pick_write;
          re_d       = ~pick_write;
          addr_d     = pick ? p1_req_address : p0_req_address;
          wdata_d    = pick ? p1_req_wdata : p0_req_wdata;
          p0_ready_d = ~pick;
          p1_ready_d = pick;
          push_en    = ~pick_write;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ctrl_ready) begin
          we_d         = 1'b0;
          re_d         = 1'b0;
          last_grant_d = winner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);

    if (pop_en) begin
      if (head_tag) begin
        p1_rsp_valid_d = 1'b1;
        p1_rsp_rdata_d = o_user_data;
      end else begin
        p0_rsp_valid_d = 1'b1;
        p0_rsp_rdata_d = o_user_data;
      end
    end
    if (ctrl_rdata_valid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // State and output registers; reset abandons any in-flight command.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 1'b1;
      winner_q       <= 1'b0;
      we_q           <= 1'b0;
      re_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      p0_ready_q     <= 1'b0;
      p1_ready_q     <= 1'b0;
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rsp_rdata_q <= '0;
      p1_rsp_rdata_q <= '0;
      err_q          <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      winner_q       <= winner_d;
      we_q           <= we_d;
      re_q           <= re_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      p0_ready_q     <= p0_ready_d;
      p1_ready_q     <= p1_ready_d;
      p0_rsp_valid_q <= p0_rsp_valid_d;
      p1_rsp_valid_q <= p1_rsp_valid_d;
      p0_rsp_rdata_q <= p0_rsp_rdata_d;
      p1_rsp_rdata_q <= p1_rsp_rdata_d;
      err_q          <= err_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // Tag write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      tag_mem[wr_ptr_q] <= pick;
    end
  end

  assign p0_req_ready        = p0_ready_q;
  assign p1_req_ready        = p1_ready_q;
  assign p0_rsp_valid        = p0_rsp_valid_q;
  assign p1_rsp_valid        = p1_rsp_valid_q;
  assign p0_rsp_rdata        = p0_rsp_rdata_q;
  assign p1_rsp_rdata        = p1_rsp_rdata_q;
  assign write_enable        = we_q;
  assign read_enable         = re_q;
  assign i_user_data_address = addr_q;
  assign i_user_data         = wdata_q;
  assign err_unexpected      = err_q;

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Directed testbench for ddr3_user_port_arbiter. Expected values follow the
// ARB_WRITE_PRIORITY_EN macro where arbitration depends on it.
module tb_ddr3_user_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          p0_req_valid, p0_req_write, p0_req_ready, p0_rsp_valid;
  logic [AW-1:0] p0_req_address;
  logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_write, p1_req_ready, p1_rsp_valid;
  logic [AW-1:0] p1_req_address;
  logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
  logic          write_enable, read_enable, ctrl_ready, ctrl_rdata_valid, err_unexpected;
  logic [AW-1:0] i_user_data_address;
  logic [DW-1:0] i_user_data, o_user_data;

  int checks = 0;
  int errors = 0;
  logic exp_p1;

  always #5 clk = ~clk;

  ddr3_user_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .p0_req_valid(p0_req_valid), .p0_req_write(p0_req_write),
    .p0_req_address(p0_req_address), .p0_req_wdata(p0_req_wdata),
    .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_write(p1_req_write),
    .p1_req_address(p1_req_address), .p1_req_wdata(p1_req_wdata),
    .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
    .ctrl_ready(ctrl_ready), .ctrl_rdata_valid(ctrl_rdata_valid),
    .o_user_data(o_user_data), .err_unexpected(err_unexpected)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for its ready pulse, drop it, let ISSUE finish.
  task automatic issue(input string tag, input bit port, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    if (port) begin
      p1_req_valid = 1'b1; p1_req_write = wr; p1_req_address = a; p1_req_wdata = d;
    end else begin
      p0_req_valid = 1'b1; p0_req_write = wr; p0_req_address = a; p0_req_wdata = d;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = port ? p1_req_ready : p0_req_ready;
    end
    chk(tag, {31'd0, got}, 32'd1);
    $display("txn %s: port %0d %s addr %h", tag, port, wr ? "write" : "read", a);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    p0_req_valid = 0; p0_req_write = 0; p0_req_address = '0; p0_req_wdata = '0;
    p1_req_valid = 0; p1_req_write = 0; p1_req_address = '0; p1_req_wdata = '0;
    ctrl_ready = 0; ctrl_rdata_valid = 0; o_user_data = '0;
    tick(); tick();
    chk("rst_we", {31'd0, write_enable}, 0);
    chk("rst_re", {31'd0, read_enable}, 0);
    chk("rst_rdy", {30'd0, p1_req_ready, p0_req_ready}, 0);
    chk("rst_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
    chk("rst_err", {31'd0, err_unexpected}, 0);
    chk("rst_addr", {14'd0, i_user_data_address}, 0);
    resetn = 1'b1;

    // A: simultaneous requests, p0 wins first tie, then p1
    p0_req_valid = 1; p0_req_write = 1; p0_req_address = 18'h10; p0_req_wdata = 16'hA5A5;
    p1_req_valid = 1; p1_req_write = 0; p1_req_address = 18'h20;
    ctrl_ready = 1;
    tick();
    chk("A_p0_ready", {31'd0, p0_req_ready}, 1);
    chk("A_p1_ready", {31'd0, p1_req_ready}, 0);
    chk("A_we", {31'd0, write_enable}, 1);
    chk("A_re", {31'd0, read_enable}, 0);
    chk("A_addr", {14'd0, i_user_data_address}, 32'h10);
    chk("A_data", {16'd0, i_user_data}, 32'hA5A5);
    $display("txn A: p0 write granted");
    p0_req_valid = 0;
    tick();
    chk("A_we_drop", {31'd0, write_enable}, 0);
    chk("A_p0_ready_drop", {31'd0, p0_req_ready}, 0);
    tick();
    chk("A_p1_re", {31'd0, read_enable}, 1);
    chk("A_p1_we", {31'd0, write_enable}, 0);
    chk("A_p1_addr", {14'd0, i_user_data_address}, 32'h20);
    chk("A_p1_ready", {31'd0, p1_req_ready}, 1);
    $display("txn A: p1 read granted");
    p1_req_valid = 0;
    tick();
    chk("A_re_drop", {31'd0, read_enable}, 0);
    ctrl_rdata_valid = 1; o_user_data = 16'hBEEF;
    tick();
    chk("A_rsp_p1", {31'd0, p1_rsp_valid}, 1);
    chk("A_rsp_p0", {31'd0, p0_rsp_valid}, 0);
    chk("A_rdata", {16'd0, p1_rsp_rdata}, 32'hBEEF);
    ctrl_rdata_valid = 0;
    tick();
    chk("A_rsp_drop", {31'd0, p1_rsp_valid}, 0);
    chk("A_rdata_hold", {16'd0, p1_rsp_rdata}, 32'hBEEF);

    // B: in-order routing of alternating reads
    issue("B_rd0", 0, 0, 18'h01, 16'h0);
    issue("B_rd1", 1, 0, 18'h03, 16'h0);
    issue("B_rd2", 0, 0, 18'h02, 16'h0);
    ctrl_rdata_valid = 1; o_user_data = 16'h1111;
    tick();
    chk("B_rsp1_p0", {31'd0, p0_rsp_valid}, 1);
    chk("B_rsp1_p1", {31'd0, p1_rsp_valid}, 0);
    chk("B_rsp1_data", {16'd0, p0_rsp_rdata}, 32'h1111);
    o_user_data = 16'h2222;
    tick();
    chk("B_rsp2_p1", {31'd0, p1_rsp_valid}, 1);
    chk("B_rsp2_p0", {31'd0, p0_rsp_valid}, 0);
    chk("B_rsp2_data", {16'd0, p1_rsp_rdata}, 32'h2222);
    chk("B_rsp2_p0hold", {16'd0, p0_rsp_rdata}, 32'h1111);
    o_user_data = 16'h3333;
    tick();
    chk("B_rsp3_p0", {31'd0, p0_rsp_valid}, 1);
    chk("B_rsp3_p1", {31'd0, p1_rsp_valid}, 0);
    chk("B_rsp3_data", {16'd0, p0_rsp_rdata}, 32'h3333);
    ctrl_rdata_valid = 0;
    tick();
    chk("B_idle_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
    chk("B_err", {31'd0, err_unexpected}, 0);

    // C: tag FIFO full blocks reads but not writes; a pop frees a slot
    for (int i = 0; i < 4; i++) issue("C_fill", 0, 0, 18'(32'h30 + i), 16'h0);
    p0_req_valid = 1; p0_req_write = 0; p0_req_address = 18'h35;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("C_full_ready", {31'd0, p0_req_ready}, 0);
      chk("C_full_re", {31'd0, read_enable}, 0);
    end
    p0_req_write = 1; p0_req_address = 18'h40; p0_req_wdata = 16'h4040;
    tick();
    chk("C_wr_ready", {31'd0, p0_req_ready}, 1);
    chk("C_wr_we", {31'd0, write_enable}, 1);
    $display("txn C: write accepted with full tag FIFO");
    p0_req_valid = 0;
    tick();
    p0_req_valid = 1; p0_req_write = 0; p0_req_address = 18'h50;
    ctrl_rdata_valid = 1; o_user_data = 16'h4444;
    tick();
    chk("C_5th_ready", {31'd0, p0_req_ready}, 1);
    chk("C_5th_re", {31'd0, read_enable}, 1);
    chk("C_pop_rsp", {31'd0, p0_rsp_valid}, 1);
    chk("C_pop_data", {16'd0, p0_rsp_rdata}, 32'h4444);
    $display("txn C: 5th read accepted on pop");
    p0_req_valid = 0; ctrl_rdata_valid = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      ctrl_rdata_valid = 1; o_user_data = 16'(32'h5000 + i);
      tick();
      chk("C_drain_rsp", {31'd0, p0_rsp_valid}, 1);
      chk("C_drain_data", {16'd0, p0_rsp_rdata}, 32'h5000 + i);
    end
    ctrl_rdata_valid = 0;
    tick();
    chk("C_err", {31'd0, err_unexpected}, 0);

    // D: controller stall holds the command stable
    ctrl_ready = 0;
    p1_req_valid = 1; p1_req_write = 1; p1_req_address = 18'h77; p1_req_wdata = 16'h1234;
    tick();
    chk("D_we", {31'd0, write_enable}, 1);
    chk("D_p1_ready", {31'd0, p1_req_ready}, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("D_hold_we", {31'd0, write_enable}, 1);
      chk("D_hold_re", {31'd0, read_enable}, 0);
      chk("D_hold_addr", {14'd0, i_user_data_address}, 32'h77);
      chk("D_hold_data", {16'd0, i_user_data}, 32'h1234);
      chk("D_no_repulse", {31'd0, p1_req_ready}, 0);
    end
    p1_req_valid = 0; ctrl_ready = 1;
    tick();
    chk("D_we_drop", {31'd0, write_enable}, 0);
    $display("txn D: stalled write completed");

    // E: read data with no outstanding tag
    ctrl_rdata_valid = 1; o_user_data = 16'hDEAD;
    tick();
    chk("E_err", {31'd0, err_unexpected}, 1);
    chk("E_no_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
    ctrl_rdata_valid = 0;
    tick();
    chk("E_err_sticky", {31'd0, err_unexpected}, 1);

    // F: p0 read vs p1 write with last_grant = 1
`ifdef ARB_WRITE_PRIORITY_EN
    exp_p1 = 1'b1;
`else
    exp_p1 = 1'b0;
`endif
    ctrl_ready = 0;
    p0_req_valid = 1; p0_req_write = 0; p0_req_address = 18'h60;
    p1_req_valid = 1; p1_req_write = 1; p1_req_address = 18'h61; p1_req_wdata = 16'h6161;
    tick();
    chk("F_p0_ready", {31'd0, p0_req_ready}, {31'd0, ~exp_p1});
    chk("F_p1_ready", {31'd0, p1_req_ready}, {31'd0, exp_p1});
    chk("F_we", {31'd0, write_enable}, {31'd0, exp_p1});
    chk("F_re", {31'd0, read_enable}, {31'd0, ~exp_p1});
    chk("F_addr", {14'd0, i_user_data_address}, exp_p1 ? 32'h61 : 32'h60);

    // G: asynchronous reset in ISSUE
    #3 resetn = 1'b0;
    #1;
    chk("G_we", {31'd0, write_enable}, 0);
    chk("G_re", {31'd0, read_enable}, 0);
    chk("G_err", {31'd0, err_unexpected}, 0);
    tick(); tick();
    p0_req_write = 1; p0_req_address = 18'h70; p0_req_wdata = 16'h7070;
    p1_req_write = 1; p1_req_address = 18'h71;
    ctrl_ready = 1;
    resetn = 1'b1;
    tick();
    chk("G_p0_wins", {31'd0, p0_req_ready}, 1);
    chk("G_p1_waits", {31'd0, p1_req_ready}, 0);
    chk("G_addr", {14'd0, i_user_data_address}, 32'h70);
    p0_req_valid = 0;
    tick();
    tick();
    chk("G_p1_next", {31'd0, p1_req_ready}, 1);
    p1_req_valid = 0;
    tick();
    ctrl_rdata_valid = 1;
    tick();
    chk("G_fifo_empty_err", {31'd0, err_unexpected}, 1);
    chk("G_fifo_empty_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 0);
    ctrl_rdata_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
